// File: rtl/pipe_pkg.sv
// pipe_pkg: shared widths, reset/bubble constants and IF/ID record for the fetch stage
package pipe_pkg;
    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam int RS1_HI = 19;
    localparam int RS1_LO = 15;
    localparam int RS2_HI = 24;
    localparam int RS2_LO = 20;
    localparam int RD_HI = 11;
    localparam int RD_LO = 7;
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
        logic            valid;
    } if_id_t;
endpackage

// File: rtl/hazard_detect_unit.sv
// hazard_detect_unit: flags a load in EX whose rd feeds either source field of the instruction in ID
module hazard_detect_unit (
    input  logic [4:0] rs1_i,
    input  logic [4:0] rs2_i,
    input  logic       valid_i,
    input  logic       ex_memread_i,
    input  logic [4:0] ex_rdaddr_i,
    output logic       hazard_o
);
    // Both source fields are compared for every opcode; an occasional false stall is harmless
    assign hazard_o = valid_i & ex_memread_i & (ex_rdaddr_i != 5'd0) &
                      ((ex_rdaddr_i == rs1_i) | (ex_rdaddr_i == rs2_i));
endmodule

// File: rtl/if_id_stage.sv
// if_id_stage: PC register, instruction fetch and IF/ID pipeline register with load-use stall and branch redirect
module if_id_stage
    import pipe_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_i,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic [31:0]     imem_rdata_i,
    input  logic            imem_ready_i,
    input  logic            branch_taken_i,
    input  logic [XLEN-1:0] branch_target_i,
    input  logic            ex_memread_i,
    input  logic [4:0]      ex_rdaddr_i,
    output logic [XLEN-1:0] pc_o,
    output logic [31:0]     instr_o,
    output logic            valid_o,
    output logic            stall_o,
    output logic            flush_o
);
    logic [XLEN-1:0] pc_q, pc_d;
    if_id_t          if_id_q, if_id_d;
    logic            hazard;
    logic            unused_tgt_lsb;

    hazard_detect_unit u_hdu (
        .rs1_i        (if_id_q.instr[RS1_HI:RS1_LO]),
        .rs2_i        (if_id_q.instr[RS2_HI:RS2_LO]),
        .valid_i      (if_id_q.valid),
        .ex_memread_i (ex_memread_i),
        .ex_rdaddr_i  (ex_rdaddr_i),
        .hazard_o     (hazard)
    );

    // Redirect targets are word-aligned, so the low bits of the target are dropped
    assign unused_tgt_lsb = ^branch_target_i[1:0];
    assign imem_addr_o    = pc_q;
    assign pc_o           = if_id_q.pc;
    assign instr_o        = if_id_q.instr;
    assign valid_o        = if_id_q.valid;
    assign stall_o        = hazard;
    assign flush_o        = branch_taken_i & if_id_q.valid & ~hazard;

    // Next state: stall holds everything, redirect or missing fetch inserts a bubble, otherwise advance
    always_comb begin
        pc_d    = hazard          ? pc_q :
                  flush_o         ? {branch_target_i[XLEN-1:2], 2'b00} :
                  imem_ready_i    ? pc_q + XLEN'(4) : pc_q;
        if_id_d = hazard                   ? if_id_q :
                  (flush_o | ~imem_ready_i) ? if_id_t'{pc: if_id_q.pc, instr: NOP_INSTR, valid: 1'b0} :
                                              if_id_t'{pc: pc_q, instr: imem_rdata_i, valid: 1'b1};
    end

    // PC and IF/ID registers with synchronous active-low reset
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            pc_q    <= RESET_PC;
            if_id_q <= if_id_t'{pc: '0, instr: NOP_INSTR, valid: 1'b0};
        end else begin
            pc_q    <= pc_d;
            if_id_q <= if_id_d;
        end
    end
endmodule

// File: tb/tb_if_id_stage.sv
// tb_if_id_stage: scoreboard bench comparing the fetch stage against a behavioural pipeline model
module tb_if_id_stage;
    import pipe_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic [31:0] imem_addr_o, imem_rdata_i = '0, branch_target_i = '0;
    logic        imem_ready_i = 1'b0, branch_taken_i = 1'b0, ex_memread_i = 1'b0;
    logic [4:0]  ex_rdaddr_i = '0;
    logic [31:0] pc_o, instr_o;
    logic        valid_o, stall_o, flush_o;

    always #5 clk_i = ~clk_i;

    if_id_stage dut (
        .clk_i(clk_i), .rst_i(rst_i), .imem_addr_o(imem_addr_o), .imem_rdata_i(imem_rdata_i),
        .imem_ready_i(imem_ready_i), .branch_taken_i(branch_taken_i), .branch_target_i(branch_target_i),
        .ex_memread_i(ex_memread_i), .ex_rdaddr_i(ex_rdaddr_i), .pc_o(pc_o), .instr_o(instr_o),
        .valid_o(valid_o), .stall_o(stall_o), .flush_o(flush_o)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] pc;
        logic [31:0] instr;
        logic        valid;
        logic        stall;
        logic        flush;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int passed = 0;
    int total = 0;

    // Behavioural model: fetch pointer plus the instruction currently sitting in decode
    bit          known = 0;
    logic [31:0] m_pc, m_opc, m_instr;
    logic        m_valid;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic step(input logic rst, input logic rdy, input logic [31:0] rdata, input logic bt,
                        input logic [31:0] tgt, input logic mr, input logic [4:0] rd);
        bit haz, fl;
        @(posedge clk_i);
        #1;
        rst_i = rst; imem_ready_i = rdy; imem_rdata_i = rdata; branch_taken_i = bt;
        branch_target_i = tgt; ex_memread_i = mr; ex_rdaddr_i = rd;
        haz = known && m_valid && mr && rd != 0 && (rd == m_instr[19:15] || rd == m_instr[24:20]);
        fl  = known && bt && m_valid && !haz;
        if (known) q.push_back('{m_pc, m_opc, m_instr, m_valid, haz, fl});
        if (!rst) begin
            known = 1; m_pc = 32'h0; m_opc = 32'h0; m_instr = 32'h13; m_valid = 0;
        end else if (haz) begin
        end else if (fl) begin
            m_pc = (tgt / 4) * 4; m_instr = 32'h13; m_valid = 0;
        end else if (!rdy) begin
            m_instr = 32'h13; m_valid = 0;
        end else begin
            m_opc = m_pc; m_instr = rdata; m_valid = 1;
            m_pc = 32'((64'(m_pc) + 4) % 64'h1_0000_0000);
        end
    endtask

    task automatic idle();
        step(1, 1, $urandom, 0, 0, 0, 0);
    endtask

    task automatic rand_step();
        logic [4:0]  rd;
        logic [31:0] ins;
        int          sel;
        sel = int'($urandom_range(0, 3));
        rd  = sel == 0 ? m_instr[19:15] : sel == 1 ? m_instr[24:20] : sel == 2 ? 5'd0 : 5'($urandom);
        ins = $urandom;
        if ($urandom_range(0, 3) == 0) ins[19:15] = 5'd0;
        step($urandom_range(0, 49) != 0, $urandom_range(0, 3) != 0, ins, $urandom_range(0, 5) == 0,
             $urandom, $urandom_range(0, 1) == 1, rd);
    endtask

    // Monitor: every falling edge, pop the expected view of this cycle and compare with the DUT
    initial begin
        forever begin
            @(negedge clk_i);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("imem_addr", imem_addr_o, e.addr);
                chk("pc_o", pc_o, e.pc);
                chk("instr_o", instr_o, e.instr);
                chk("valid_o", 32'(valid_o), 32'(e.valid));
                chk("stall_o", 32'(stall_o), 32'(e.stall));
                chk("flush_o", 32'(flush_o), 32'(e.flush));
            end
        end
    end

    initial begin
        step(0, 1, 32'h1, 0, 0, 0, 0);
        step(0, 1, 32'h2, 1, 32'h40, 1, 5);
        step(1, 1, 32'h0000_0111, 0, 0, 0, 0);
        step(1, 1, 32'h0000_0222, 0, 0, 0, 0);
        step(1, 1, 32'h0000_0333, 0, 0, 0, 0);
        step(1, 1, 32'h0000_0444, 0, 0, 0, 0);
        step(1, 1, 32'h0072_8333, 0, 0, 0, 0);
        step(1, 1, 32'h0000_0555, 0, 0, 1, 5);
        step(1, 1, 32'h0000_0555, 0, 0, 0, 0);
        step(1, 1, 32'h0000_0013, 0, 0, 0, 0);
        step(1, 1, 32'h0000_0666, 0, 0, 1, 0);
        step(1, 1, 32'h0000_0777, 1, 32'h0000_0103, 0, 0);
        step(1, 1, 32'h0000_0888, 0, 0, 0, 0);
        step(1, 1, 32'h0072_8333, 0, 0, 0, 0);
        step(1, 1, 32'h0000_0999, 1, 32'h0000_0200, 1, 7);
        step(1, 1, 32'h0000_0aaa, 1, 32'h0000_0200, 0, 0);
        step(1, 1, 32'h0000_0bbb, 0, 0, 0, 0);
        step(1, 1, 32'h0000_0ccc, 1, 32'hFFFF_FFFF, 0, 0);
        step(1, 0, 32'h0000_0ddd, 0, 0, 0, 0);
        step(1, 0, 32'h0000_0eee, 0, 0, 0, 0);
        step(1, 0, 32'h0000_0fff, 0, 0, 0, 0);
        step(1, 1, 32'h0072_8333, 0, 0, 0, 0);
        step(1, 1, 32'h0000_1111, 0, 0, 0, 0);
        step(1, 1, 32'h0072_8333, 0, 0, 0, 0);
        step(0, 1, 32'h0000_1222, 0, 0, 1, 5);
        idle();
        idle();
        for (int i = 0; i < 600; i++) rand_step();
        idle();
        idle();
        @(negedge clk_i);
        #1;
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
